sid_bus_sequencer: RTL and testbench

- Bus initiator for the SID register interface: accepts timed register-access commands and replays them as write strobes or read samples toward the SID core.
- Drives the core's cs/we/addr/data_in pins; captures its data_out on reads.
- Sits between a host loader or player (register-dump playback, test sequencer) and the SID core.
- Every access is aligned to the ce_1m bus-cycle enable, with programmable inter-access spacing in ce_1m ticks.

---
 rtl/sid_bus_pkg.sv | 34 +++
 rtl/sid_bus_sequencer_if.sv | 40 ++++
 rtl/sid_cmd_fifo.sv | 59 +++++
 rtl/sid_bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_sid_bus_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_bus_pkg.sv
// Shared types for the SID bus sequencer: command word, sequencer states, widths.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package sid_bus_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int DELAY_W    = 16;

    // Timed register access as queued by the host (31 bits).
    typedef struct packed {
        logic                  rd;     // 1 = read, 0 = write
        logic                  chip;   // 0 = left, 1 = right
        logic [SID_ADDR_W-1:0] addr;
        logic [7:0]            data;
        logic [DELAY_W-1:0]    delay;  // ce_1m ticks since the previous access
    } sid_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDOUT = 2'd3
    } seq_state_t;

    // True when the tick being sampled now is far enough from the last access.
    // The +1 accounts for the tick currently on ce_1m; delay 0 behaves as 1.
    function automatic logic delay_met(input logic [DELAY_W-1:0] elapsed,
                                       input logic [DELAY_W-1:0] delay);
        logic [DELAY_W:0] need;
        need = (delay == '0) ? {{DELAY_W{1'b0}}, 1'b1} : {1'b0, delay};
        return ({1'b0, elapsed} + {{DELAY_W{1'b0}}, 1'b1}) >= need;
    endfunction

endpackage

// File: rtl/sid_bus_sequencer_if.sv
// Host command channel, SID core pins and read-return channel in one bundle.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side; rd_valid is a pulse with no ready.
// Ports (master = sequencer side):
//   in : cmd_valid, cmd_rd, cmd_chip, cmd_addr, cmd_data, cmd_delay, sid_rdata
//   out: cmd_ready, sid_cs[N], sid_we, sid_addr, sid_wdata, rd_valid, rd_data, rd_chip
interface sid_bus_sequencer_if
    import sid_bus_pkg::*;
#(
    parameter int N = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rd;
    logic                  cmd_chip;
    logic [SID_ADDR_W-1:0] cmd_addr;
    logic [7:0]            cmd_data;
    logic [DELAY_W-1:0]    cmd_delay;

    logic [N-1:0]          sid_cs;
    logic                  sid_we;
    logic [SID_ADDR_W-1:0] sid_addr;
    logic [7:0]            sid_wdata;
    logic [7:0]            sid_rdata;

    logic                  rd_valid;
    logic [7:0]            rd_data;
    logic                  rd_chip;

    modport master (
        input  cmd_valid, cmd_rd, cmd_chip, cmd_addr, cmd_data, cmd_delay, sid_rdata,
        output cmd_ready, sid_cs, sid_we, sid_addr, sid_wdata, rd_valid, rd_data, rd_chip
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_chip, cmd_addr, cmd_data, cmd_delay, sid_rdata,
        input  cmd_ready, sid_cs, sid_we, sid_addr, sid_wdata, rd_valid, rd_data, rd_chip
    );

endinterface

// File: rtl/sid_cmd_fifo.sv
// Synchronous first-word-fall-through queue of sid_cmd_t.
// Latency: a pushed word is visible on head_o the cycle after the push edge.
// Backpressure: pushes while full are dropped; caller gates with !full_o. Flush wins over push/pop.
// Ports: clk, reset, push_i, pop_i, flush_i, din_i -> head_o, full_o, empty_o, level_o.
module sid_cmd_fifo
    import sid_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  sid_cmd_t                  din_i,
    output sid_cmd_t                  head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    level_o
);
    localparam int AW = $clog2(DEPTH);

    sid_cmd_t          mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/sid_bus_sequencer.sv
// Replays queued, tick-spaced register commands onto SID core pins; returns read samples.
// Latency: write strobe 1 clk after the ce_1m issue cycle; rd_valid 2 clks after it.
// Backpressure: cmd_ready = !full; read returns are unthrottled one-cycle pulses.
// Ports: clk, reset, ce_1m, flush, bus (master modport), busy, level.
module sid_bus_sequencer
    import sid_bus_pkg::*;
#(
    parameter int DUAL       = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce_1m,
    input  logic                          flush,
    sid_bus_sequencer_if.master           bus,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int N = (DUAL != 0) ? 2 : 1;

    sid_cmd_t              push_cmd;
    sid_cmd_t              head;
    logic                  full;
    logic                  empty;
    logic                  issue;
    logic [N-1:0]          cs_sel;
    logic                  chip_sel;

    seq_state_t            state_q;
    logic [DELAY_W-1:0]    elapsed_q;
    logic [N-1:0]          cs_q;
    logic                  we_q;
    logic [SID_ADDR_W-1:0] addr_q;
    logic [7:0]            wdata_q;
    logic                  acc_chip_q;
    logic                  rd_valid_q;
    logic [7:0]            rd_data_q;
    logic                  rd_chip_q;

    always_comb begin
        push_cmd       = '0;
        push_cmd.rd    = bus.cmd_rd;
        push_cmd.chip  = bus.cmd_chip;
        push_cmd.addr  = bus.cmd_addr;
        push_cmd.data  = bus.cmd_data;
        push_cmd.delay = bus.cmd_delay;
    end

    sid_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.cmd_valid),
        .pop_i   (issue),
        .flush_i (flush),
        .din_i   (push_cmd),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // Single-chip builds ignore cmd_chip entirely: cs is always asserted, chip reports 0.
    if (DUAL != 0) begin : g_dual
        assign cs_sel   = head.chip ? 2'b10 : 2'b01;
        assign chip_sel = head.chip;
    end else begin : g_single
        assign cs_sel   = 1'b1;
        assign chip_sel = 1'b0;
    end

    // Only one access can be in flight, so issue is gated on IDLE; flush blocks the pop.
    assign issue = (state_q == IDLE) && !empty && ce_1m && !flush &&
                   delay_met(elapsed_q, head.delay);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            elapsed_q  <= '0;
            cs_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            acc_chip_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_chip_q  <= 1'b0;
        end else if (flush) begin
            // Drop whatever is in flight; addr/wdata/rd_data keep their last values.
            state_q    <= IDLE;
            elapsed_q  <= '0;
            cs_q       <= '0;
            we_q       <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (issue) begin
                elapsed_q <= '0;
            end else if (ce_1m && (elapsed_q != '1)) begin
                elapsed_q <= elapsed_q + DELAY_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        cs_q       <= cs_sel;
                        addr_q     <= head.addr;
                        acc_chip_q <= chip_sel;
                        if (head.rd) begin
                            we_q    <= 1'b0;
                            state_q <= RD;
                        end else begin
                            we_q    <= 1'b1;
                            wdata_q <= head.data;
                            state_q <= WR;
                        end
                    end
                end
                WR: begin
                    we_q    <= 1'b0;
                    cs_q    <= '0;
                    state_q <= IDLE;
                end
                RD: begin
                    // sid_rdata follows sid_addr combinationally, so it is settled by now.
                    cs_q       <= '0;
                    rd_data_q  <= bus.sid_rdata;
                    rd_chip_q  <= acc_chip_q;
                    rd_valid_q <= 1'b1;
                    state_q    <= RDOUT;
                end
                RDOUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.sid_cs    = cs_q;
    assign bus.sid_we    = we_q;
    assign bus.sid_addr  = addr_q;
    assign bus.sid_wdata = wdata_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_chip   = rd_chip_q;
    assign busy          = (level != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sid_bus_sequencer.sv
// Directed bench for sid_bus_sequencer: dual-chip instance plus a single-chip instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_sid_bus_sequencer;
    import sid_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_1m;
    logic       flush;
    logic       busy1;
    logic       busy0;
    logic [4:0] level1;
    logic [4:0] level0;

    int checks = 0;
    int passed = 0;

    logic       exp_we   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] exp_addr [5] = '{5'h01, 5'h01, 5'h01, 5'h02, 5'h03};

    sid_bus_sequencer_if #(.N(2)) b1 ();
    sid_bus_sequencer_if #(.N(1)) b0 ();

    sid_bus_sequencer #(.DUAL(1), .FIFO_DEPTH(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .ce_1m (ce_1m),
        .flush (flush),
        .bus   (b1),
        .busy  (busy1),
        .level (level1)
    );

    sid_bus_sequencer #(.DUAL(0), .FIFO_DEPTH(16)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .ce_1m (ce_1m),
        .flush (flush),
        .bus   (b0),
        .busy  (busy0),
        .level (level0)
    );

    always #5 clk = ~clk;

    // SID read models: register 0x1B of the dual instance returns 0x5A.
    assign b1.sid_rdata = (b1.sid_addr == 5'h1B) ? 8'h5A : {3'b000, b1.sid_addr};
    assign b0.sid_rdata = 8'hC3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive1(input logic rd, input logic chip, input logic [4:0] addr,
                          input logic [7:0] data, input logic [15:0] delay);
        b1.cmd_valid = 1'b1;
        b1.cmd_rd    = rd;
        b1.cmd_chip  = chip;
        b1.cmd_addr  = addr;
        b1.cmd_data  = data;
        b1.cmd_delay = delay;
    endtask

    task automatic drive0(input logic rd, input logic chip, input logic [4:0] addr,
                          input logic [7:0] data, input logic [15:0] delay);
        b0.cmd_valid = 1'b1;
        b0.cmd_rd    = rd;
        b0.cmd_chip  = chip;
        b0.cmd_addr  = addr;
        b0.cmd_data  = data;
        b0.cmd_delay = delay;
    endtask

    initial begin
        reset = 1'b1;
        ce_1m = 1'b0;
        flush = 1'b0;
        b1.cmd_valid = 1'b0; b1.cmd_rd = 1'b0; b1.cmd_chip = 1'b0;
        b1.cmd_addr = '0; b1.cmd_data = '0; b1.cmd_delay = '0;
        b0.cmd_valid = 1'b0; b0.cmd_rd = 1'b0; b0.cmd_chip = 1'b0;
        b0.cmd_addr = '0; b0.cmd_data = '0; b0.cmd_delay = '0;
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", b1.cmd_ready, 1);
        chk("rst_sid_we",    b1.sid_we, 0);
        chk("rst_sid_cs",    b1.sid_cs, 0);
        chk("rst_level",     level1, 0);
        chk("rst_busy",      busy1, 0);
        chk("rst_rd_valid",  b1.rd_valid, 0);
        chk("rst_rd_data",   b1.rd_data, 0);
        reset = 1'b0;

        // Single write, delay 0: strobe on the clk after the first ce_1m
        drive1(1'b0, 1'b0, 5'h04, 8'h41, 16'd0);
        step();
        b1.cmd_valid = 1'b0;
        chk("w1_level", level1, 1);
        chk("w1_busy",  busy1, 1);
        step();
        step();
        chk("w1_no_ce_no_we", b1.sid_we, 0);
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("w1_we",    b1.sid_we, 1);
        chk("w1_cs",    b1.sid_cs, 2'b01);
        chk("w1_addr",  b1.sid_addr, 5'h04);
        chk("w1_wdata", b1.sid_wdata, 8'h41);
        chk("w1_level_after_pop", level1, 0);
        step();
        chk("w1_we_done",    b1.sid_we, 0);
        chk("w1_cs_done",    b1.sid_cs, 0);
        chk("w1_addr_hold",  b1.sid_addr, 5'h04);
        chk("w1_wdata_hold", b1.sid_wdata, 8'h41);
        chk("w1_busy_done",  busy1, 0);

        // Spacing: delays 0, 3, 1 -> strobes on ticks k, k+3, k+4
        drive1(1'b0, 1'b0, 5'h01, 8'h11, 16'd0); step();
        drive1(1'b0, 1'b0, 5'h02, 8'h22, 16'd3); step();
        drive1(1'b0, 1'b0, 5'h03, 8'h33, 16'd1); step();
        b1.cmd_valid = 1'b0;
        chk("sp_level", level1, 3);
        for (int i = 0; i < 5; i++) begin
            ce_1m = 1'b1;
            step();
            ce_1m = 1'b0;
            chk($sformatf("sp_we_tick%0d", i),   b1.sid_we, exp_we[i]);
            chk($sformatf("sp_addr_tick%0d", i), b1.sid_addr, exp_addr[i]);
            step();
            step();
            step();
        end

        // Read chip1 addr 0x1B
        drive1(1'b1, 1'b1, 5'h1B, 8'h00, 16'd0);
        step();
        b1.cmd_valid = 1'b0;
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("rd_cs",       b1.sid_cs, 2'b10);
        chk("rd_we",       b1.sid_we, 0);
        chk("rd_addr",     b1.sid_addr, 5'h1B);
        chk("rd_vld_early", b1.rd_valid, 0);
        step();
        chk("rd_valid", b1.rd_valid, 1);
        chk("rd_data",  b1.rd_data, 8'h5A);
        chk("rd_chip",  b1.rd_chip, 1);
        chk("rd_cs_off", b1.sid_cs, 0);
        step();
        chk("rd_valid_pulse", b1.rd_valid, 0);
        chk("rd_busy_done",   busy1, 0);

        // Fill to 16 with no ce_1m; 17th refused
        for (int i = 0; i < 16; i++) begin
            drive1(1'b0, 1'b0, 5'(i), 8'(8'h80 + i), 16'd0);
            step();
        end
        chk("full_level", level1, 16);
        chk("full_ready", b1.cmd_ready, 0);
        drive1(1'b0, 1'b0, 5'h10, 8'h90, 16'd0);
        step();
        chk("full_17th_refused", level1, 16);
        // Pop while full with a push offered: ready stays low, so level drops
        drive1(1'b0, 1'b0, 5'h1F, 8'hEE, 16'd0);
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        b1.cmd_valid = 1'b0;
        chk("full_pop_level", level1, 15);
        chk("full_pop_addr",  b1.sid_addr, 5'h00);
        chk("full_pop_wdata", b1.sid_wdata, 8'h80);
        step();
        chk("full_ready_back", b1.cmd_ready, 1);
        step();
        // Simultaneous push and pop keeps the level
        drive1(1'b0, 1'b0, 5'h1E, 8'hDD, 16'd0);
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        b1.cmd_valid = 1'b0;
        chk("pushpop_level", level1, 15);
        chk("pushpop_we",    b1.sid_we, 1);
        chk("pushpop_wdata", b1.sid_wdata, 8'h81);
        step();

        // Flush the backlog, then flush during a read
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush1_level", level1, 0);
        chk("flush1_busy",  busy1, 0);
        drive1(1'b1, 1'b0, 5'h05, 8'h00, 16'd0); step();
        for (int i = 0; i < 4; i++) begin
            drive1(1'b0, 1'b0, 5'(6 + i), 8'h55, 16'd0);
            step();
        end
        b1.cmd_valid = 1'b0;
        chk("fl_level5", level1, 5);
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("fl_rd_cs", b1.sid_cs, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_no_rd_valid", b1.rd_valid, 0);
        chk("fl_level",       level1, 0);
        chk("fl_busy",        busy1, 0);
        chk("fl_cs",          b1.sid_cs, 0);
        for (int i = 0; i < 3; i++) begin
            ce_1m = 1'b1;
            step();
            ce_1m = 1'b0;
            chk($sformatf("fl_quiet_we%0d", i), b1.sid_we, 0);
            chk($sformatf("fl_quiet_cs%0d", i), b1.sid_cs, 0);
            step();
            chk($sformatf("fl_quiet_rv%0d", i), b1.rd_valid, 0);
            step();
        end

        // Single-chip instance: cmd_chip ignored
        drive0(1'b1, 1'b1, 5'h02, 8'h00, 16'd0); step();
        drive0(1'b0, 1'b1, 5'h07, 8'h77, 16'd0); step();
        drive0(1'b0, 1'b1, 5'h08, 8'h78, 16'd0); step();
        b0.cmd_valid = 1'b0;
        chk("s_level", level0, 3);
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("s_rd_cs", b0.sid_cs, 1'b1);
        step();
        chk("s_rd_valid", b0.rd_valid, 1);
        chk("s_rd_chip",  b0.rd_chip, 0);
        chk("s_rd_data",  b0.rd_data, 8'hC3);
        step();
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("s_wr_we",   b0.sid_we, 1);
        chk("s_wr_cs",   b0.sid_cs, 1'b1);
        chk("s_wr_addr", b0.sid_addr, 5'h07);
        chk("s_level1",  level0, 1);
        // Reset during the write strobe
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s_rst_we",    b0.sid_we, 0);
        chk("s_rst_cs",    b0.sid_cs, 0);
        chk("s_rst_level", level0, 0);
        chk("s_rst_ready", b0.cmd_ready, 1);
        step();
        ce_1m = 1'b1;
        step();
        ce_1m = 1'b0;
        chk("s_rst_no_strobe", b0.sid_we, 0);
        chk("s_rst_busy",      busy0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
